mem_wait_responder: RTL

MEM_WAIT_RESPONDER -- requirements
Module: mem_wait_responder

---
 rtl/mem_wait_responder_pkg.sv | 18 +
 rtl/mem_bytelane_ram.sv | 44 ++++
 rtl/mem_wait_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_wait_responder_pkg.sv
// Shared types and constants for the wait-state memory responder.
// Holds the FSM state encoding, the default window base and the window-range helper.
package mem_wait_responder_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_e;

    // True when a window-relative byte offset falls inside 2^addr_w words.
    function automatic logic addr_in_window(input logic [31:0] offset, input int unsigned addr_w);
        return (offset >> (addr_w + 2)) == 32'h0;
    endfunction

endpackage

// File: rtl/mem_bytelane_ram.sv
// Single-port-per-direction word RAM with four independently enabled byte lanes.
// Registered read output; the array itself is never reset.
module mem_bytelane_ram #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              re,
    input  logic              rclr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [3:0][7:0] mem [DEPTH];
    logic [31:0]     rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (be[lane]) begin
                    mem[waddr][lane] <= wdata[8*lane +: 8];
                end
            end
        end
    end

    // rclr substitutes zero for accesses that must not touch the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'h0;
        end else if (re) begin
            rdata_q <= rclr ? 32'h0 : mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_wait_responder.sv
// Memory-mapped word responder that stalls the CPU for WAIT_CYCLES before completing.
// Flags out-of-window, read+write and unstable-request misuse in a sticky protocol_error.
module mem_wait_responder
    import mem_wait_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        protocol_error
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [29:0]       lat_addr_q;
    logic              lat_read_q, lat_write_q, lat_bad_q;
    logic [3:0]        lat_be_q;
    logic [31:0]       lat_wdata_q;
    logic [ADDR_W-1:0] lat_index_q;
    logic              error_q;

    logic              req;
    logic [31:0]       offset;
    logic              cur_bad;
    logic [ADDR_W-1:0] cur_index;
    logic              changed;
    logic              latch;
    logic              set_err;
    logic              ram_re, ram_clr, ram_we;
    logic [ADDR_W-1:0] ram_raddr;

    assign req       = read | write;
    assign offset    = address - BASE_ADDR;
    assign cur_index = offset[ADDR_W+1:2];
    assign cur_bad   = !addr_in_window(offset, ADDR_W) || (read && write);
    assign changed   = !req || (address[31:2] != lat_addr_q) ||
                       (read != lat_read_q) || (write != lat_write_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        set_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    latch   = 1'b1;
                    set_err = cur_bad;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES > 1) ? WAIT : RESPOND;
                end
            end
            WAIT: begin
                if (changed) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    set_err = 1'b1;
                end else begin
                    // Counter reaches zero on the edge that enters RESPOND.
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = RESPOND;
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lat_addr_q  <= 30'h0;
            lat_read_q  <= 1'b0;
            lat_write_q <= 1'b0;
            lat_bad_q   <= 1'b0;
            lat_be_q    <= 4'h0;
            lat_wdata_q <= 32'h0;
            lat_index_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                lat_addr_q  <= address[31:2];
                lat_read_q  <= read;
                lat_write_q <= write;
                lat_bad_q   <= cur_bad;
                lat_be_q    <= byteenable;
                lat_wdata_q <= writedata;
                lat_index_q <= cur_index;
            end
            if (set_err) begin
                error_q <= 1'b1;
            end
        end
    end

    // With a single wait cycle RESPOND is entered straight from IDLE, before the latch.
    always_comb begin
        ram_re    = (state_d == RESPOND) && (state_q != RESPOND);
        ram_raddr = (state_q == IDLE) ? cur_index : lat_index_q;
        ram_clr   = (state_q == IDLE) ? cur_bad : lat_bad_q;
        ram_we    = (state_q == RESPOND) && lat_write_q && !lat_bad_q;
    end

    mem_bytelane_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .re    (ram_re),
        .rclr  (ram_clr),
        .raddr (ram_raddr),
        .we    (ram_we),
        .be    (lat_be_q),
        .waddr (lat_index_q),
        .wdata (lat_wdata_q),
        .rdata (readdata)
    );

    assign waitrequest    = req && (state_q != RESPOND);
    assign protocol_error = error_q;

endmodule
